seg7_mux_counter: RTL and testbench

Parametrised multi-digit BCD counter with time-multiplexed 7-segment output; next generation of the single-digit `dut_7segment` display block. Counts up or down on a prescaled tick, supports parallel load and wrap signalling, and scans DIGITS digits onto one shared 8-bit segment bus with a one-hot digit select. Sits between the board clock and the display pins.

---
 rtl/seg7_mux_counter_if.sv | 25 ++
 rtl/seg7_mux_counter.sv | 156 +++++++++++++++
 tb/tb_seg7_mux_counter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_counter_if.sv
// Bundles the count-control inputs and display outputs of seg7_mux_counter.
// The master modport is the driver side (board logic or bench); the slave
// modport is the counter itself.
interface seg7_mux_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, up, load, load_val,
    input  count, wrap, seg, an
  );

  modport slave (
    input  en, up, load, load_val,
    output count, wrap, seg, an
  );
endinterface

// File: rtl/seg7_mux_counter.sv
// Multi-digit BCD up/down counter with a prescaled count tick, parallel load,
// wrap pulse, and a time-multiplexed 7-segment scan (one-hot digit select).
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits
// (never digit 0) on the segment bus; the count itself is unaffected.
module seg7_mux_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1,
  parameter int SCAN_DIV = 1
) (
  input logic               clk,
  input logic               rst,
  seg7_mux_counter_if.slave bus
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int CW  = 4 * DIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]     count_q,    count_d;
  logic              wrap_q,     wrap_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [7:0]        seg_q,      seg_d;
  logic [DIGITS-1:0] an_q,       an_d;

  logic [CW-1:0] inc_val, dec_val, load_clamped;
  logic          inc_wrap, dec_wrap;
  logic          tick;

  // Digit value to active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // BCD increment/decrement candidates and the clamped load value.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic       carry, borrow;
    logic [3:0] nib;
    inc_val      = '0;
    dec_val      = '0;
    load_clamped = '0;
    carry        = 1'b1;
    borrow       = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      nib = count_q[4*k +: 4];
      if (carry && nib == 4'd9) begin
        inc_val[4*k +: 4] = 4'd0;
      end else begin
        inc_val[4*k +: 4] = carry ? nib + 4'd1 : nib;
        carry             = 1'b0;
      end
      if (borrow && nib == 4'd0) begin
        dec_val[4*k +: 4] = 4'd9;
      end else begin
        dec_val[4*k +: 4] = borrow ? nib - 4'd1 : nib;
        borrow            = 1'b0;
      end
      nib = bus.load_val[4*k +: 4];
      load_clamped[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end

  assign tick = bus.en && (tick_cnt_q == TICK_LAST);

  // Count path: load beats tick, tick beats hold; wrap only on a real roll.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (bus.load) begin
      count_d    = load_clamped;
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      count_d    = bus.up ? inc_val  : dec_val;
      wrap_d     = bus.up ? inc_wrap : dec_wrap;
    end else if (bus.en) begin
      tick_cnt_d = TW'(tick_cnt_q + 1'b1);
    end
  end

  // Scan path: free-running slot timer and digit index, plus the registered
  // segment/anode values for the digit currently selected.
  always_comb begin
    int         sel;
    logic [3:0] digit;
    scan_cnt_d = TW'(0) == '0 ? SW'(scan_cnt_q + 1'b1) : '0;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : IW'(scan_idx_q + 1'b1);
    end
    sel   = int'(scan_idx_q);
    digit = count_q[4*sel +: 4];
    seg_d = {1'b0, decode(digit)};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything above it are zero.
    if (sel != 0 && (count_q >> (4*sel)) == '0) begin
      seg_d = 8'h00;
    end
`endif
    an_d      = '0;
    an_d[sel] = 1'b1;
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= 8'h00;
      an_q       <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Self-checking bench for seg7_mux_counter. Four instances with different
// DIGITS/TICK_DIV/SCAN_DIV share one stimulus stream; each is checked every
// cycle against an arithmetic reference model, with directed checks on top.
module tb_seg7_mux_counter;

  localparam int N = 4;
  localparam int DIGS [N] = '{2, 2, 2, 1};
  localparam int TDIV [N] = '{1, 4, 1, 2};
  localparam int SDIV [N] = '{1, 1, 3, 2};
  localparam logic [7:0] SEG_TAB [10] =
    '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LEAD_ZERO_SEG = 8'h00;
`else
  localparam logic [7:0] LEAD_ZERO_SEG = 8'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_val;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seg7_mux_counter_if #(.DIGITS(2)) if_a ();
  seg7_mux_counter_if #(.DIGITS(2)) if_b ();
  seg7_mux_counter_if #(.DIGITS(2)) if_c ();
  seg7_mux_counter_if #(.DIGITS(1)) if_d ();

  seg7_mux_counter #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  seg7_mux_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  seg7_mux_counter #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(3))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  seg7_mux_counter #(.DIGITS(1), .TICK_DIV(2), .SCAN_DIV(2))
    dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  assign if_a.en = en; assign if_a.up = up; assign if_a.load = load; assign if_a.load_val = load_val;
  assign if_b.en = en; assign if_b.up = up; assign if_b.load = load; assign if_b.load_val = load_val;
  assign if_c.en = en; assign if_c.up = up; assign if_c.load = load; assign if_c.load_val = load_val;
  assign if_d.en = en; assign if_d.up = up; assign if_d.load = load; assign if_d.load_val = load_val[3:0];

  logic [7:0] obs_cnt [N];
  logic       obs_wrap[N];
  logic [7:0] obs_seg [N];
  logic [1:0] obs_an  [N];

  assign obs_cnt[0] = if_a.count;         assign obs_cnt[1] = if_b.count;
  assign obs_cnt[2] = if_c.count;         assign obs_cnt[3] = {4'h0, if_d.count};
  assign obs_wrap[0] = if_a.wrap;         assign obs_wrap[1] = if_b.wrap;
  assign obs_wrap[2] = if_c.wrap;         assign obs_wrap[3] = if_d.wrap;
  assign obs_seg[0] = if_a.seg;           assign obs_seg[1] = if_b.seg;
  assign obs_seg[2] = if_c.seg;           assign obs_seg[3] = if_d.seg;
  assign obs_an[0]  = if_a.an;            assign obs_an[1]  = if_b.an;
  assign obs_an[2]  = if_c.an;            assign obs_an[3]  = {1'b0, if_d.an};

  // Reference model: count as a plain integer, time as cycles since reset.
  int         m_cnt  [N];  // counter value as an integer 0 .. 10^DIGITS-1
  int         m_encyc[N];  // enabled cycles since reset/load
  int         m_cyc  [N];  // cycles since reset release
  logic       m_wrap [N];
  logic [7:0] m_seg  [N];
  logic [1:0] m_an   [N];

  function automatic int pow10(input int e);
    int r = 1;
    for (int j = 0; j < e; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_load(input logic [7:0] lv, input int d);
    int         v = 0;
    logic [7:0] t = lv;
    for (int k = 0; k < d; k++) begin
      int nib = int'(t[3:0]);
      v = v + ((nib > 9) ? 9 : nib) * pow10(k);
      t = t >> 4;
    end
    return v;
  endfunction

  function automatic logic [7:0] disp(input int v, input int s);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (s > 0 && v < pow10(s)) return 8'h00;
`endif
    return SEG_TAB[(v / pow10(s)) % 10];
  endfunction

  task automatic model_edge();
    int s, top;
    for (int i = 0; i < N; i++) begin
      top = pow10(DIGS[i]) - 1;
      if (rst) begin
        m_cnt[i] = 0; m_encyc[i] = 0; m_cyc[i] = 0;
        m_wrap[i] = 1'b0; m_seg[i] = 8'h00; m_an[i] = 2'b00;
      end else begin
        s = (m_cyc[i] / SDIV[i]) % DIGS[i];
        m_seg[i] = disp(m_cnt[i], s);
        m_an[i]  = 2'(1 << s);
        m_cyc[i]++;
        m_wrap[i] = 1'b0;
        if (load) begin
          m_cnt[i]   = clamp_load(load_val, DIGS[i]);
          m_encyc[i] = 0;
        end else if (en) begin
          m_encyc[i]++;
          if (m_encyc[i] % TDIV[i] == 0) begin
            if (up) begin
              m_wrap[i] = (m_cnt[i] == top);
              m_cnt[i]  = (m_cnt[i] == top) ? 0 : m_cnt[i] + 1;
            end else begin
              m_wrap[i] = (m_cnt[i] == 0);
              m_cnt[i]  = (m_cnt[i] == 0) ? top : m_cnt[i] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < N; i++) begin
      check($sformatf("count[%0d]", i), obs_cnt[i], to_bcd(m_cnt[i]));
      check($sformatf("wrap[%0d]", i), {7'b0, obs_wrap[i]}, {7'b0, m_wrap[i]});
      check($sformatf("seg[%0d]", i), obs_seg[i], m_seg[i]);
      check($sformatf("an[%0d]", i), {6'b0, obs_an[i]}, {6'b0, m_an[i]});
    end
  endtask

  // One clock: model follows the edge, outputs are compared mid-low-phase.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int wraps;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;

    // Reset held three cycles.
    repeat (3) cycle();
    check("rst_count", obs_cnt[0], 8'h00);
    check("rst_seg", obs_seg[0], 8'h00);
    check("rst_an", {6'b0, obs_an[0]}, 8'h00);

    // First edge after release shows digit 0 of count 0.
    rst = 1'b0;
    cycle();
    check("rel_an", {6'b0, obs_an[0]}, 8'h01);
    check("rel_seg", obs_seg[0], 8'h3F);

    // 100 up-ticks from 00: exactly one wrap, ending back at 00.
    en = 1'b1; up = 1'b1; wraps = 0;
    for (int t = 0; t < 100; t++) begin
      cycle();
      if (t == 9) check("carry_09_10", obs_cnt[0], 8'h10);
      if (obs_wrap[0]) wraps++;
    end
    check("up_wraps", 8'(wraps), 8'd1);
    check("up_end", obs_cnt[0], 8'h00);

    // Load 01, then count down through 00 into 99 with wrap.
    en = 1'b0; load = 1'b1; load_val = 8'h01;
    cycle();
    load = 1'b0; en = 1'b1; up = 1'b0;
    cycle();
    check("dn_00", obs_cnt[0], 8'h00);
    check("dn_00_wrap", {7'b0, obs_wrap[0]}, 8'h00);
    cycle();
    check("dn_99", obs_cnt[0], 8'h99);
    check("dn_99_wrap", {7'b0, obs_wrap[0]}, 8'h01);

    // Out-of-range digit clamps to 9.
    en = 1'b0; load = 1'b1; load_val = 8'hA3;
    cycle();
    check("ld_clamp", obs_cnt[0], 8'h93);

    // Load colliding with a rolling tick: load wins, no wrap.
    load_val = 8'h99;
    cycle();
    en = 1'b1; up = 1'b1; load_val = 8'h00;
    cycle();
    check("ld_tick_cnt", obs_cnt[0], 8'h00);
    check("ld_tick_wrap", {7'b0, obs_wrap[0]}, 8'h00);

    // Prescaler pause on the TICK_DIV=4 instance.
    load = 1'b0;
    en = 1'b1; cycle(); cycle();
    en = 1'b0; cycle(); cycle();
    en = 1'b1; cycle();
    check("pre_hold", obs_cnt[1], 8'h00);
    cycle();
    check("pre_step", obs_cnt[1], 8'h01);

    // Held count 47: scan alternates digits.
    en = 1'b0; load = 1'b1; load_val = 8'h47;
    cycle();
    load = 1'b0;
    cycle();
    for (int t = 0; t < 6; t++) begin
      cycle();
      if (obs_an[0] == 2'b01) check("scan_d0", obs_seg[0], 8'h07);
      else                    check("scan_d1", obs_seg[0], 8'h66);
    end

    // Count 05: leading zero on digit 1, digit 0 shows 5.
    load = 1'b1; load_val = 8'h05;
    cycle();
    load = 1'b0;
    cycle();
    for (int t = 0; t < 4; t++) begin
      cycle();
      if (obs_an[0] == 2'b10) check("lead_zero", obs_seg[0], LEAD_ZERO_SEG);
      else                    check("digit0_5", obs_seg[0], 8'h6D);
    end

    // Count 00: digit 0 is never blanked.
    load = 1'b1; load_val = 8'h00;
    cycle();
    load = 1'b0;
    cycle();
    for (int t = 0; t < 2; t++) begin
      cycle();
      if (obs_an[0] == 2'b01) check("zero_d0", obs_seg[0], 8'h3F);
    end

    // Randomised traffic, including occasional mid-run resets.
    for (int t = 0; t < 400; t++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
